// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial packed-BCD adder.
package bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand and result handshake bundle for bcd_serial_add_ctrl.
interface bcd_serial_add_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  co;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, co, err, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, co, err, busy
  );
endinterface

// File: rtl/adder10_0.sv
// Single-digit BCD adder: s = (a+b+ci) mod 10, co = (a+b+ci) >= 10.
module adder10_0 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    adj = raw - 5'd10;
    co  = raw >= 5'd10;
    s   = co ? adj[3:0] : raw[3:0];
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one shared digit adder, LSD first,
// carry held in a register between digits.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIGITS - 1);

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_sh;
  logic            carry_r;
  logic            err_r;
  logic [CntW-1:0] cnt;

  logic [3:0]      dig_s;
  logic            dig_co;
  logic [W-1:0]    sum_sh_nx;
  logic            in_err;
  logic            accept;

  adder10_0 u_adder (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry_r),
    .s  (dig_s),
    .co (dig_co)
  );

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd_digit(bus.a[4*i +: 4]) || !is_bcd_digit(bus.b[4*i +: 4])) begin
        in_err = 1'b1;
      end
    end
  end

  // New digit enters at the top so the LSD ends in [3:0] after DIGITS shifts.
  assign sum_sh_nx = (sum_sh >> 4) | (W'(dig_s) << (W - 4));
  assign accept    = (state == StIdle) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_r <= bus.cin;
            sum_sh  <= '0;
            cnt     <= '0;
            err_r   <= in_err;
            state   <= StRun;
          end
        end
        StRun: begin
          sum_sh  <= sum_sh_nx;
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          carry_r <= dig_co;
          cnt     <= cnt + 1'b1;
          if (cnt == CntLast) begin
            state <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == StIdle);
    bus.out_valid = (state == StDone);
    bus.busy      = (state == StRun) || (state == StDone);
    bus.sum       = '0;
    bus.co        = 1'b0;
    bus.err       = 1'b0;
    if (state == StDone) begin
      bus.err = err_r;
      // A bad input digit makes the arithmetic meaningless, so hide it.
      if (!err_r) begin
        bus.sum = sum_sh;
        bus.co  = carry_r;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: spec vectors, handshake corner cases, random ops vs a decimal model.
module tb_bcd_serial_add_ctrl;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         co;
    logic         err;
  } vec_t;

  logic watch = 1'b0;
  logic saw_valid = 1'b0;
  always @(posedge clk) if (watch && bus.out_valid) saw_valid <= 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Decimal reference: convert operands to integers, add, convert back.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    vec_t v;
    longint va = 0, vb = 0, lim = 1, tot, r;
    v.a = a; v.b = b; v.cin = cin; v.err = 1'b0; v.sum = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) v.err = 1'b1;
      va = va * 10 + longint'(a[4*i +: 4]);
      vb = vb * 10 + longint'(b[4*i +: 4]);
      lim = lim * 10;
    end
    tot  = va + vb + longint'(cin);
    v.co = (tot >= lim);
    r    = tot % lim;
    for (int i = 0; i < int'(DIGITS); i++) begin
      v.sum[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (v.err) begin
      v.sum = '0;
      v.co  = 1'b0;
    end
    return v;
  endfunction

  // Called #1 after the accept edge; waits for DONE and checks result.
  task automatic wait_done(input vec_t v, input string tag);
    int lat = 0;
    chk({tag, ".in_ready_run"}, 64'(bus.in_ready), 64'd0);
    while (!bus.out_valid && lat < 3 * DIGITS + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(DIGITS));
    chk({tag, ".sum"}, 64'(bus.sum), 64'(v.sum));
    chk({tag, ".co"},  64'(bus.co),  64'(v.co));
    chk({tag, ".err"}, 64'(bus.err), 64'(v.err));
  endtask

  task automatic issue(input vec_t v, input string tag);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(v, tag);
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_clr"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{a:16'h1234, b:16'h4321, cin:1'b0, sum:16'h5555, co:1'b0, err:1'b0};
    tbl[1] = '{a:16'h9999, b:16'h0001, cin:1'b0, sum:16'h0000, co:1'b1, err:1'b0};
    tbl[2] = '{a:16'h9999, b:16'h9999, cin:1'b1, sum:16'h9999, co:1'b1, err:1'b0};
    tbl[3] = '{a:16'h0000, b:16'h0000, cin:1'b1, sum:16'h0001, co:1'b0, err:1'b0};
    tbl[4] = '{a:16'h12A4, b:16'h0001, cin:1'b0, sum:16'h0000, co:1'b0, err:1'b1};
    tbl[5] = '{a:16'h0005, b:16'h0005, cin:1'b0, sum:16'h0010, co:1'b0, err:1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset.busy",      64'(bus.busy),      64'd0);
    chk("reset.sum",       64'(bus.sum),       64'd0);
    chk("reset.co_err",    64'({bus.co, bus.err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i], $sformatf("vec%0d", i));
      retire($sformatf("vec%0d", i));
    end

    // Stall in DONE with a new op pending: outputs hold, nothing is accepted.
    issue(tbl[0], "stall");
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall%0d.in_ready", i),  64'(bus.in_ready),  64'd0);
      chk($sformatf("stall%0d.sum_co", i), 64'({bus.co, bus.sum}), 64'({1'b0, 16'h5555}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("stall.idle_after_release", 64'({bus.in_ready, bus.busy}), 64'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(model(16'h1111, 16'h2222, 1'b0), "stall.next");
    retire("stall.next");

    // Reset two clocks into RUN: the aborted op must never reach DONE.
    bus.a = 16'h4567; bus.b = 16'h1111; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    watch = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready",  64'(bus.in_ready),  64'd1);
    chk("abort.out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort.busy",      64'(bus.busy),      64'd0);
    chk("abort.sum_co_err", 64'({bus.err, bus.co, bus.sum}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (DIGITS + 3) @(posedge clk);
    #1;
    chk("abort.no_valid_pulse", 64'(saw_valid), 64'd0);
    watch = 1'b0;
    issue(tbl[0].a == 0 ? tbl[0] : model(16'h0758, 16'h0267, 1'b0), "abort.next");
    chk("abort.next_sum_const", 64'(bus.sum), 64'h1025);
    retire("abort.next");

    // Random operands, mostly legal BCD with occasional bad digits.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      for (int d = 0; d < int'(DIGITS); d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      end
      v = model(ra, rb, 1'($urandom_range(0, 1)));
      issue(v, $sformatf("rnd%0d", n));
      retire($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
